// File: rtl/fft_addr_gen.sv
// Sequencer and address generator for a radix-2 DIT FFT: bit-reversed load addresses, then per-stage butterfly A/B/twiddle addresses.
// Latency: all outputs are combinational from the current state and counters, so addresses appear in the same cycle as their strobe.
// Backpressure: Enable low freezes every register; In_Valid low stalls the load counter without leaving LOAD.
module fft_addr_gen #(
  parameter int LOG2N    = 3,
  parameter int BFLY_LAT = 2
) (
  input  logic             Clk,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Enable,
  input  logic             In_Valid,
  output logic             Ld_En,
  output logic [LOG2N-1:0] Ld_Addr,
  output logic             Bf_Valid,
  output logic [LOG2N-1:0] Addr_A,
  output logic [LOG2N-1:0] Addr_B,
  output logic [LOG2N-2:0] Tw_Idx,
  output logic [1:0]       Stage,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Terminal counts for each counter.
  localparam logic [LOG2N-1:0] LD_LAST   = '1;
  localparam logic [LOG2N-2:0] BF_LAST   = '1;
  localparam logic [1:0]       STG_LAST  = 2'(LOG2N - 1);
  localparam logic [2:0]       WAIT_LAST = 3'(BFLY_LAT - 1);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] ld_cnt_q, ld_cnt_d;
  logic [LOG2N-2:0] bf_cnt_q, bf_cnt_d;
  logic [1:0]       stage_q, stage_d;
  logic [2:0]       wait_cnt_q, wait_cnt_d;

  // State and counter registers; async reset aborts any run in progress.
  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      ld_cnt_q   <= '0;
      bf_cnt_q   <= '0;
      stage_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      bf_cnt_q   <= bf_cnt_d;
      stage_q    <= stage_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and counter advance; nothing moves while Enable is low.
  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    bf_cnt_d   = bf_cnt_q;
    stage_d    = stage_q;
    wait_cnt_d = wait_cnt_q;
    if (Enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_d    = S_LOAD;
            ld_cnt_d   = '0;
            bf_cnt_d   = '0;
            stage_d    = '0;
            wait_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (In_Valid) begin
            if (ld_cnt_q == LD_LAST) begin
              state_d  = S_COMPUTE;
              ld_cnt_d = '0;
            end else begin
              ld_cnt_d = ld_cnt_q + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (bf_cnt_q == BF_LAST) begin
            bf_cnt_d = '0;
            if (BFLY_LAT == 0) begin
              // No drain gap: roll straight into the next stage.
              if (stage_q == STG_LAST) state_d = S_DONE;
              else                     stage_d = stage_q + 1'b1;
            end else begin
              state_d    = S_WAIT;
              wait_cnt_d = '0;
            end
          end else begin
            bf_cnt_d = bf_cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d = '0;
            if (stage_q == STG_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_COMPUTE;
              stage_d = stage_q + 1'b1;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          stage_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  logic [LOG2N-1:0] b_ext, span, pos, grp, addr_a, tw_full, ld_rev;

  // Butterfly address/twiddle arithmetic and bit-reversed load address.
  always_comb begin
    b_ext   = LOG2N'(bf_cnt_q);
    span    = LOG2N'(1) << stage_q;
    pos     = b_ext & (span - LOG2N'(1));
    grp     = b_ext >> stage_q;
    addr_a  = ((grp << stage_q) << 1) + pos;
    tw_full = pos << (LOG2N - 1 - int'(stage_q));
    ld_rev  = '0;
    for (int i = 0; i < LOG2N; i++) ld_rev[i] = ld_cnt_q[LOG2N-1-i];

    Ld_En    = In_Valid & Enable & (state_q == S_LOAD);
    Ld_Addr  = (state_q == S_LOAD) ? ld_rev : '0;
    Bf_Valid = Enable & (state_q == S_COMPUTE);
    Addr_A   = '0;
    Addr_B   = '0;
    Tw_Idx   = '0;
    if (state_q == S_COMPUTE) begin
      Addr_A = addr_a;
      Addr_B = addr_a + span;
      Tw_Idx = tw_full[LOG2N-2:0];
    end
    Stage = (state_q == S_COMPUTE || state_q == S_WAIT) ? stage_q : 2'd0;
    Busy  = (state_q != S_IDLE);
    Done  = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: two builds (BFLY_LAT=2 and 0) share stimulus, each checked every cycle against a schedule model.
// Directed runs pin the nominal Done cycle, Enable stalls, In_Valid gaps and mid-run reset; then a randomized soak.
// All comparisons go through one checking task.
module tb_fft_addr_gen;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int NB    = N / 2;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic Clk = 1'b0;
  logic RSTn = 1'b0;
  logic Start = 1'b0;
  logic Enable = 1'b0;
  logic In_Valid = 1'b0;

  logic             ld_en    [2];
  logic [LOG2N-1:0] ld_addr  [2];
  logic             bf_valid [2];
  logic [LOG2N-1:0] addr_a   [2];
  logic [LOG2N-1:0] addr_b   [2];
  logic [LOG2N-2:0] tw_idx   [2];
  logic [1:0]       stage    [2];
  logic             busy     [2];
  logic             done     [2];

  always #5 Clk = ~Clk;

  fft_addr_gen #(.LOG2N(LOG2N), .BFLY_LAT(2)) dut_lat2 (
    .Clk(Clk), .RSTn(RSTn), .Start(Start), .Enable(Enable), .In_Valid(In_Valid),
    .Ld_En(ld_en[0]), .Ld_Addr(ld_addr[0]), .Bf_Valid(bf_valid[0]),
    .Addr_A(addr_a[0]), .Addr_B(addr_b[0]), .Tw_Idx(tw_idx[0]), .Stage(stage[0]),
    .Busy(busy[0]), .Done(done[0])
  );

  fft_addr_gen #(.LOG2N(LOG2N), .BFLY_LAT(0)) dut_lat0 (
    .Clk(Clk), .RSTn(RSTn), .Start(Start), .Enable(Enable), .In_Valid(In_Valid),
    .Ld_En(ld_en[1]), .Ld_Addr(ld_addr[1]), .Bf_Valid(bf_valid[1]),
    .Addr_A(addr_a[1]), .Addr_B(addr_b[1]), .Tw_Idx(tw_idx[1]), .Stage(stage[1]),
    .Busy(busy[1]), .Done(done[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a run is N accepted samples followed by a flat timeline
  // of LOG2N slots, each NB issue cycles plus LAT drain cycles.
  int lat_v [2] = '{2, 0};
  int m_mode [2];
  int m_ld   [2];
  int m_t    [2];

  int cyc;
  int done_at [2];
  int bf_seen [2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, obs, exp, cyc, $time);
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (((v >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // The r-th index (ascending) whose stage bit s is clear is the top operand.
  function automatic int nth_top(input int s, input int r);
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (((i >> s) & 1) == 0) begin
        if (c == r) return i;
        c++;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE;
      m_ld[k]   = 0;
      m_t[k]    = 0;
    end
  endtask

  task automatic model_step(input int k, input logic st, input logic en, input logic iv);
    int per;
    per = NB + lat_v[k];
    if (en) begin
      case (m_mode[k])
        M_IDLE: if (st) begin m_mode[k] = M_LOAD; m_ld[k] = 0; end
        M_LOAD: if (iv) begin
          if (m_ld[k] == N - 1) begin m_mode[k] = M_RUN; m_t[k] = 0; end
          else m_ld[k]++;
        end
        M_RUN: begin
          m_t[k]++;
          if (m_t[k] == LOG2N * per) m_mode[k] = M_DONE;
        end
        default: m_mode[k] = M_IDLE;
      endcase
    end
  endtask

  task automatic check_outputs(input int k);
    int per, s, r, ea, eb, etw, estg, ebv;
    string p;
    p   = (k == 0) ? "lat2" : "lat0";
    per = NB + lat_v[k];
    ea = 0; eb = 0; etw = 0; estg = 0; ebv = 0;
    if (m_mode[k] == M_RUN) begin
      s    = m_t[k] / per;
      r    = m_t[k] % per;
      estg = s;
      if (r < NB) begin
        ebv = int'(Enable);
        ea  = nth_top(s, r);
        eb  = ea + (1 << s);
        etw = (ea % (1 << s)) * (N >> (s + 1));
      end
    end
    chk({p, ".ld_en"},   int'(ld_en[k]),   int'(In_Valid && Enable && m_mode[k] == M_LOAD));
    chk({p, ".ld_addr"}, int'(ld_addr[k]), (m_mode[k] == M_LOAD) ? bitrev(m_ld[k]) : 0);
    chk({p, ".bf_valid"}, int'(bf_valid[k]), ebv);
    chk({p, ".addr_a"},  int'(addr_a[k]),  ea);
    chk({p, ".addr_b"},  int'(addr_b[k]),  eb);
    chk({p, ".tw_idx"},  int'(tw_idx[k]),  etw);
    chk({p, ".stage"},   int'(stage[k]),   estg);
    chk({p, ".busy"},    int'(busy[k]),    int'(m_mode[k] != M_IDLE));
    chk({p, ".done"},    int'(done[k]),    int'(m_mode[k] == M_DONE));
  endtask

  // One clock: drive inputs, check mid-cycle, then advance the model at the edge.
  task automatic tick(input logic st, input logic en, input logic iv);
    Start = st; Enable = en; In_Valid = iv;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      check_outputs(k);
      if (done[k] && done_at[k] < 0) done_at[k] = cyc;
      if (bf_valid[k]) bf_seen[k]++;
    end
    @(posedge Clk);
    for (int k = 0; k < 2; k++) model_step(k, st, en, iv);
    cyc++;
    #1;
  endtask

  task automatic mid_reset();
    #2;
    RSTn = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check_outputs(k);
    @(posedge Clk);
    #1;
    RSTn = 1'b1;
  endtask

  // Settle to IDLE, then issue a single Start pulse at edge 0.
  task automatic begin_run();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin done_at[k] = -1; bf_seen[k] = 0; end
    cyc = 0;
    tick(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    model_reset();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin done_at[k] = -1; bf_seen[k] = 0; end

    // Reset state.
    RSTn = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) check_outputs(k);
    @(negedge Clk);
    @(posedge Clk);
    #1;
    RSTn = 1'b1;

    // Nominal run.
    begin_run();
    while (cyc < 32) tick(1'b0, 1'b1, 1'b1);
    chk("nominal.done_cycle.lat2", done_at[0], 27);
    chk("nominal.done_cycle.lat0", done_at[1], 21);
    chk("nominal.bf_count.lat2", bf_seen[0], 12);
    chk("nominal.bf_count.lat0", bf_seen[1], 12);

    // Enable low for cycles 17-19 (stage1 b=2 on the LAT=2 build), Start pulsed mid-compute.
    begin_run();
    while (cyc < 36) tick(cyc == 12, !(cyc >= 17 && cyc <= 19), 1'b1);
    chk("stall.done_cycle.lat2", done_at[0], 30);
    chk("stall.done_cycle.lat0", done_at[1], 24);
    chk("stall.bf_count.lat2", bf_seen[0], 12);

    // In_Valid alternating: 8 samples accepted on odd cycles 1..15.
    begin_run();
    while (cyc < 40) tick(1'b0, 1'b1, cyc[0]);
    chk("gaps.done_cycle.lat2", done_at[0], 34);
    chk("gaps.done_cycle.lat0", done_at[1], 28);

    // Reset during stage1 WAIT of the LAT=2 build, then a clean run.
    begin_run();
    while (cyc < 20) tick(1'b0, 1'b1, 1'b1);
    mid_reset();
    for (int k = 0; k < 2; k++) done_at[k] = -1;
    while (cyc < 32) tick(1'b0, 1'b1, 1'b1);
    chk("abort.no_done.lat2", done_at[0], -1);
    begin_run();
    while (cyc < 32) tick(1'b0, 1'b1, 1'b1);
    chk("rerun.done_cycle.lat2", done_at[0], 27);
    chk("rerun.done_cycle.lat0", done_at[1], 21);

    // Randomized soak.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
